// File: rtl/loss_of_beam_qualifier.sv
// Qualifies the per-turn loss-of-beam comparator level over N consecutive turns.
// On a trip it latches the turn number, pulses an event, flips a toggle and holds sticky status.
module loss_of_beam_qualifier #(
    parameter int DATA_WIDTH   = 32,
    parameter int TURN_WIDTH   = 32,
    parameter int CONSEC_WIDTH = 8,
    parameter int SAMPLE_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  turnByTurnToggle,
    input  logic                  lossOfBeamTrigger,
    input  logic [DATA_WIDTH-1:0] gpioData,
    input  logic                  countStrobe,
    input  logic                  armStrobe,
    input  logic                  disarmStrobe,
    input  logic                  clearStrobe,
    output logic                  tripped,
    output logic                  lossOfBeamEvent,
    output logic                  eventToggle,
    output logic [TURN_WIDTH-1:0] tripTurn,
    output logic [TURN_WIDTH-1:0] turnCounter,
    output logic [DATA_WIDTH-1:0] status
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRIPPED  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(SAMPLE_DELAY + 1);
    localparam logic [CNT_W-1:0]        DELAY_LOAD = CNT_W'(SAMPLE_DELAY);
    localparam logic [CNT_W-1:0]        DELAY_LAST = CNT_W'(1);
    localparam logic [CONSEC_WIDTH-1:0] CONSEC_MAX = '1;
    localparam logic [CONSEC_WIDTH-1:0] CONSEC_ONE = CONSEC_WIDTH'(1);

    state_t                  state;
    logic [CONSEC_WIDTH-1:0] required_count;
    logic [CONSEC_WIDTH-1:0] consec_count;
    logic [CNT_W-1:0]        delay_cnt;
    logic                    toggle_match;
    logic                    primed;

    logic                    toggle_edge;
    logic                    sample_strobe;
    logic [CONSEC_WIDTH-1:0] consec_inc;
    logic [CONSEC_WIDTH-1:0] effective_count;
    logic                    trip_now;
    logic                    unused_gpio;

    assign unused_gpio = ^gpioData[DATA_WIDTH-1:CONSEC_WIDTH];

    // primed stays low for the first clock after reset so the match register can load without an edge
    assign toggle_edge     = primed && (turnByTurnToggle != toggle_match);
    assign sample_strobe   = (delay_cnt == DELAY_LAST) && !toggle_edge;
    assign consec_inc      = (consec_count == CONSEC_MAX) ? consec_count : consec_count + CONSEC_ONE;
    assign effective_count = (required_count == '0) ? CONSEC_ONE : required_count;
    assign trip_now        = (state == ARMED) && sample_strobe && lossOfBeamTrigger
                             && (consec_inc >= effective_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed       <= 1'b0;
            toggle_match <= 1'b0;
            turnCounter  <= '0;
        end else begin
            primed       <= 1'b1;
            toggle_match <= turnByTurnToggle;
            if (toggle_edge) begin
                turnCounter <= turnCounter + TURN_WIDTH'(1);
            end
        end
    end

    // a new edge restarts the countdown, dropping any sample still pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt <= '0;
        end else if (toggle_edge) begin
            delay_cnt <= DELAY_LOAD;
        end else if (delay_cnt != '0) begin
            delay_cnt <= delay_cnt - DELAY_LAST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            required_count <= CONSEC_ONE;
        end else if (countStrobe) begin
            required_count <= gpioData[CONSEC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= DISARMED;
            consec_count    <= '0;
            tripped         <= 1'b0;
            tripTurn        <= '0;
            lossOfBeamEvent <= 1'b0;
            eventToggle     <= 1'b0;
        end else begin
            lossOfBeamEvent <= 1'b0;
            // a trip outranks any disarm or clear arriving in the same cycle
            if (trip_now) begin
                state           <= TRIPPED;
                consec_count    <= consec_inc;
                tripped         <= 1'b1;
                tripTurn        <= turnCounter;
                lossOfBeamEvent <= 1'b1;
                eventToggle     <= ~eventToggle;
            end else begin
                if (clearStrobe) begin
                    tripped <= 1'b0;
                end
                case (state)
                    DISARMED: begin
                        consec_count <= '0;
                        if (armStrobe && !disarmStrobe) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (disarmStrobe) begin
                            state        <= DISARMED;
                            consec_count <= '0;
                        end else if (sample_strobe) begin
                            consec_count <= lossOfBeamTrigger ? consec_inc : '0;
                        end
                    end
                    TRIPPED: begin
                        if (clearStrobe || disarmStrobe) begin
                            state        <= DISARMED;
                            consec_count <= '0;
                        end
                    end
                    default: begin
                        state        <= DISARMED;
                        consec_count <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        status = '0;
        status[DATA_WIDTH-1:DATA_WIDTH-2] = state;
        status[DATA_WIDTH-3]              = tripped;
        status[CONSEC_WIDTH+7:8]          = consec_count;
        status[CONSEC_WIDTH-1:0]          = required_count;
    end

endmodule

// File: tb/tb_loss_of_beam_qualifier.sv
// Directed bench for loss_of_beam_qualifier: vector table for the consecutive-turn
// counting plus hand sequences for event timing, strobe collisions and reset.
module tb_loss_of_beam_qualifier;

    localparam int SAMPLE_DELAY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        turnByTurnToggle;
    logic        lossOfBeamTrigger;
    logic [31:0] gpioData;
    logic        countStrobe;
    logic        armStrobe;
    logic        disarmStrobe;
    logic        clearStrobe;
    logic        tripped;
    logic        lossOfBeamEvent;
    logic        eventToggle;
    logic [31:0] tripTurn;
    logic [31:0] turnCounter;
    logic [31:0] status;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       trig;
        logic [7:0] exp_consec;
        logic       exp_tripped;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[6];

    loss_of_beam_qualifier #(
        .DATA_WIDTH  (32),
        .TURN_WIDTH  (32),
        .CONSEC_WIDTH(8),
        .SAMPLE_DELAY(SAMPLE_DELAY)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .turnByTurnToggle (turnByTurnToggle),
        .lossOfBeamTrigger(lossOfBeamTrigger),
        .gpioData         (gpioData),
        .countStrobe      (countStrobe),
        .armStrobe        (armStrobe),
        .disarmStrobe     (disarmStrobe),
        .clearStrobe      (clearStrobe),
        .tripped          (tripped),
        .lossOfBeamEvent  (lossOfBeamEvent),
        .eventToggle      (eventToggle),
        .tripTurn         (tripTurn),
        .turnCounter      (turnCounter),
        .status           (status)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic strobes(input logic cnt, input logic arm, input logic dis, input logic clr, input logic [31:0] data);
        countStrobe  = cnt;
        armStrobe    = arm;
        disarmStrobe = dis;
        clearStrobe  = clr;
        gpioData     = data;
        tick(1);
        countStrobe  = 1'b0;
        armStrobe    = 1'b0;
        disarmStrobe = 1'b0;
        clearStrobe  = 1'b0;
        gpioData     = '0;
    endtask

    // one full turn: flip the toggle and wait past the sample and any event
    task automatic applyStimulus(input logic trig);
        lossOfBeamTrigger = trig;
        turnByTurnToggle  = ~turnByTurnToggle;
        tick(SAMPLE_DELAY + 2);
    endtask

    initial begin
        int events_seen;

        vecs[0] = '{1'b1, 8'd1, 1'b0, 2'd1};
        vecs[1] = '{1'b1, 8'd2, 1'b0, 2'd1};
        vecs[2] = '{1'b0, 8'd0, 1'b0, 2'd1};
        vecs[3] = '{1'b1, 8'd1, 1'b0, 2'd1};
        vecs[4] = '{1'b1, 8'd2, 1'b0, 2'd1};
        vecs[5] = '{1'b1, 8'd3, 1'b1, 2'd2};

        rst_n             = 1'b0;
        turnByTurnToggle  = 1'b1;
        lossOfBeamTrigger = 1'b0;
        gpioData          = '0;
        countStrobe       = 1'b0;
        armStrobe         = 1'b0;
        disarmStrobe      = 1'b0;
        clearStrobe       = 1'b0;
        tick(3);
        checkOutput("reset_status", status, 32'h0000_0001);
        checkOutput("reset_turn", turnCounter, 32'd0);

        rst_n = 1'b1;
        tick(4);
        checkOutput("release_turn", turnCounter, 32'd0);
        checkOutput("release_status", status, 32'h0000_0001);

        for (int i = 0; i < 9; i++) applyStimulus(1'b1);
        checkOutput("disarmed_turns", turnCounter, 32'd9);
        checkOutput("disarmed_ignore", status, 32'h0000_0001);

        strobes(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("disarm_beats_arm", status, 32'h0000_0001);

        strobes(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF03);
        checkOutput("count_load", status, 32'h0000_0003);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("armed", status, 32'h4000_0003);

        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("two_high", status, 32'h4000_0203);

        lossOfBeamTrigger = 1'b1;
        turnByTurnToggle  = ~turnByTurnToggle;
        tick(SAMPLE_DELAY);
        checkOutput("event_early", {31'd0, lossOfBeamEvent}, 32'd0);
        tick(1);
        checkOutput("event_on_time", {31'd0, lossOfBeamEvent}, 32'd1);
        checkOutput("trip_turn_12", tripTurn, 32'd12);
        checkOutput("event_toggle_1", {31'd0, eventToggle}, 32'd1);
        tick(1);
        checkOutput("event_one_cycle", {31'd0, lossOfBeamEvent}, 32'd0);
        checkOutput("tripped_status", status, 32'hA000_0303);

        strobes(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        checkOutput("clear_arm", status, 32'h0000_0003);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("rearm", status, 32'h4000_0003);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].trig);
            checkOutput($sformatf("vec%0d_status", i), status,
                        {vecs[i].exp_state, vecs[i].exp_tripped, 13'd0, vecs[i].exp_consec, 8'd3});
        end
        checkOutput("vec_trip_turn", tripTurn, 32'd18);
        checkOutput("vec_event_toggle", {31'd0, eventToggle}, 32'd0);

        strobes(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("clear_only", status, 32'h0000_0003);

        // zero count acts as one; a second edge inside the countdown discards the first sample
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("armed_zero", status, 32'h4000_0000);
        lossOfBeamTrigger = 1'b1;
        turnByTurnToggle  = ~turnByTurnToggle;
        tick(2);
        turnByTurnToggle  = ~turnByTurnToggle;
        for (int k = 1; k <= SAMPLE_DELAY; k++) begin
            tick(1);
            checkOutput($sformatf("reload_no_event%0d", k), {31'd0, lossOfBeamEvent}, 32'd0);
        end
        tick(1);
        checkOutput("reload_event", {31'd0, lossOfBeamEvent}, 32'd1);
        checkOutput("reload_turns", turnCounter, 32'd20);
        checkOutput("reload_trip_turn", tripTurn, 32'd20);
        tick(1);
        checkOutput("reload_status", status, 32'hA000_0100);

        strobes(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("armed_one", status, 32'h4000_0001);
        lossOfBeamTrigger = 1'b1;
        turnByTurnToggle  = ~turnByTurnToggle;
        tick(2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_turn", turnCounter, 32'd0);
        checkOutput("mid_reset_trip_turn", tripTurn, 32'd0);
        checkOutput("mid_reset_flags", {28'd0, tripped, lossOfBeamEvent, eventToggle, 1'b0}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        events_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (lossOfBeamEvent) events_seen++;
        end
        checkOutput("post_reset_no_event", events_seen, 32'd0);
        checkOutput("post_reset_status", status, 32'h0000_0001);
        checkOutput("post_reset_turn", turnCounter, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
